// File: rtl/led_fade_pwm.sv
// Per-LED brightness fader: linearly ramps an 8-bit level toward the GPIO on/off target
// and drives each pin with a 255-cycle PWM derived from that level.
module led_fade_pwm #(
  parameter int unsigned N_LED    = 8,
  parameter int unsigned STEP_DIV = 3906
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_LED-1:0] gpio_in,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  localparam int unsigned LVL_W = 8;
  localparam int unsigned PRE_W = 16;
  localparam int unsigned PWM_W = 8;

  localparam logic [LVL_W-1:0] LVL_MIN  = LVL_W'(0);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(255);
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(254);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  // Implicit per-channel fade state, derived each cycle from tgt and lvl
  localparam logic [1:0] ST_HOLD_OFF = 2'd0;
  localparam logic [1:0] ST_RISING   = 2'd1;
  localparam logic [1:0] ST_FALLING  = 2'd2;
  localparam logic [1:0] ST_HOLD_ON  = 2'd3;

  logic [N_LED-1:0] tgt;
  logic [LVL_W-1:0] lvl       [N_LED];
  logic [LVL_W-1:0] lvl_nxt_c [N_LED];
  logic [1:0]       chan_st_c [N_LED];
  logic [PRE_W-1:0] prescaler;
  logic [PWM_W-1:0] pwm_cnt;
  logic             step_tick_c;
  logic [N_LED-1:0] led_nxt_c;
  logic             busy_nxt_c;

  // Channel classification, next level, PWM compare and busy reduction
  always_comb begin
    step_tick_c = (prescaler == PRE_LAST);
    led_nxt_c   = '0;
    busy_nxt_c  = 1'b0;
    for (int i = 0; i < int'(N_LED); i++) begin
      chan_st_c[i] = ST_HOLD_OFF;
      lvl_nxt_c[i] = lvl[i];
      if (tgt[i]) begin
        chan_st_c[i] = (lvl[i] == LVL_MAX) ? ST_HOLD_ON : ST_RISING;
      end else begin
        chan_st_c[i] = (lvl[i] == LVL_MIN) ? ST_HOLD_OFF : ST_FALLING;
      end
      case (chan_st_c[i])
        ST_RISING:  lvl_nxt_c[i] = lvl[i] + LVL_W'(1);
        ST_FALLING: lvl_nxt_c[i] = lvl[i] - LVL_W'(1);
        default:    lvl_nxt_c[i] = lvl[i];
      endcase
      if ((chan_st_c[i] == ST_RISING) || (chan_st_c[i] == ST_FALLING)) begin
        busy_nxt_c = 1'b1;
      end
      led_nxt_c[i] = (pwm_cnt < lvl[i]);
    end
  end

  // All state; reset wins over any fade in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt       <= '0;
      prescaler <= '0;
      pwm_cnt   <= '0;
      led_out   <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(N_LED); i++) begin
        lvl[i] <= '0;
      end
    end else begin
      tgt       <= gpio_in;
      prescaler <= step_tick_c ? '0 : prescaler + PRE_W'(1);
      pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_W'(1);
      led_out   <= led_nxt_c;
      busy      <= busy_nxt_c;
      if (step_tick_c) begin
        for (int i = 0; i < int'(N_LED); i++) begin
          lvl[i] <= lvl_nxt_c[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm: reset, fade-in, PWM duty, reversal, mixed channels,
// and reset mid-fade, using instances at STEP_DIV of 4, 1 and 256.
module tb_led_fade_pwm;

  logic       clk;
  logic       rst;
  logic [7:0] gpio4, gpio1, gpiod;
  logic [7:0] led4, led1, ledd;
  logic       busy4, busy1, busyd;

  int n_checks;
  int n_errors;

  led_fade_pwm #(.N_LED(8), .STEP_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .gpio_in(gpio4), .led_out(led4), .busy(busy4)
  );
  led_fade_pwm #(.N_LED(8), .STEP_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .gpio_in(gpio1), .led_out(led1), .busy(busy1)
  );
  led_fade_pwm #(.N_LED(8), .STEP_DIV(256)) dutd (
    .clk(clk), .rst(rst), .gpio_in(gpiod), .led_out(ledd), .busy(busyd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    int reach, hi_bad, const_bad, bad, peak, prev, cur, cnt;
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    gpio4 = 8'h00;
    gpio1 = 8'h00;
    gpiod = 8'h00;

    // Reset with all targets on: outputs stay low throughout and just after
    gpio4 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_led", 32'(led4), 32'h00);
      check("rst_busy", 32'(busy4), 32'd0);
    end
    rst = 1'b0;
    tick();
    check("rst_after_led", 32'(led4), 32'h00);
    check("rst_after_busy", 32'(busy4), 32'd0);
    tick();
    check("rst_after2_busy", 32'(busy4), 32'd1);

    // Fade in channel 0 at STEP_DIV=4: first step 4 cycles after release, 255 steps
    gpio4 = 8'h00;
    apply_reset(3);
    gpio4 = 8'h01;
    tick();
    check("fadein_busy_lat1", 32'(busy4), 32'd0);
    tick();
    check("fadein_busy_lat2", 32'(busy4), 32'd1);
    reach  = 0;
    hi_bad = 0;
    for (int n = 3; n <= 1100; n++) begin
      tick();
      if (led4[7:1] != 7'd0) hi_bad = 1;
      if (dut4.lvl[0] == 8'd255) begin
        reach = n;
        break;
      end
    end
    check("fadein_cycles", 32'(reach), 32'd1020);
    tick();
    check("fadein_busy_done", 32'(busy4), 32'd0);
    const_bad = 0;
    for (int n = 0; n < 255; n++) begin
      if (led4 != 8'h01) const_bad = 1;
      tick();
    end
    check("fadein_led_const", 32'(const_bad), 32'd0);
    check("fadein_others_off", 32'(hi_bad), 32'd0);

    // Reversal at lvl=100: holds 100 until next tick, then falls by one per tick
    apply_reset(2);
    gpio4 = 8'h01;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (dut4.lvl[0] == 8'd100) break;
    end
    check("rev_start", 32'(dut4.lvl[0]), 32'd100);
    gpio4 = 8'h00;
    prev = 100;
    peak = 100;
    bad  = 0;
    cur  = 100;
    for (int n = 0; n < 600; n++) begin
      tick();
      cur = int'(dut4.lvl[0]);
      if (cur > peak) peak = cur;
      if (cur != prev && cur != prev - 1) bad = 1;
      prev = cur;
      if (cur == 0) break;
    end
    check("rev_end_lvl", 32'(cur), 32'd0);
    check("rev_peak", 32'(peak), 32'd100);
    check("rev_no_jump", 32'(bad), 32'd0);
    check("rev_busy_at_zero", 32'(busy4), 32'd1);
    tick();
    check("rev_busy_fall", 32'(busy4), 32'd0);

    // Mixed channels at STEP_DIV=1: upper nibble falls from 255, lower holds
    gpio4 = 8'h00;
    gpio1 = 8'hFF;
    apply_reset(2);
    repeat (300) tick();
    check("mix_settled_led", 32'(led1), 32'hFF);
    check("mix_settled_busy", 32'(busy1), 32'd0);
    gpio1 = 8'h0F;
    repeat (2) tick();
    check("mix_lvl4_t2", 32'(dut1.lvl[4]), 32'd254);
    check("mix_lvl0_t2", 32'(dut1.lvl[0]), 32'd255);
    repeat (99) tick();
    check("mix_lvl7_t101", 32'(dut1.lvl[7]), 32'd155);
    check("mix_lvl3_t101", 32'(dut1.lvl[3]), 32'd255);
    repeat (155) tick();
    check("mix_lvl5_t256", 32'(dut1.lvl[5]), 32'd0);
    check("mix_busy_t256", 32'(busy1), 32'd1);
    tick();
    check("mix_led_t257", 32'(led1), 32'h0F);
    check("mix_busy_t257", 32'(busy1), 32'd0);
    const_bad = 0;
    for (int n = 0; n < 255; n++) begin
      tick();
      if (led1 != 8'h0F || busy1 != 1'b0) const_bad = 1;
    end
    check("mix_led_const", 32'(const_bad), 32'd0);

    // Reset mid-fade on channel 2, then restart from zero with target still on
    gpio1 = 8'h00;
    apply_reset(2);
    gpio4 = 8'h04;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (dut4.lvl[2] == 8'd60) break;
    end
    check("mid_reach60", 32'(dut4.lvl[2]), 32'd60);
    rst = 1'b1;
    tick();
    check("mid_rst_lvl", 32'(dut4.lvl[2]), 32'd0);
    check("mid_rst_led", 32'(led4), 32'h00);
    check("mid_rst_busy", 32'(busy4), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_r1_busy", 32'(busy4), 32'd0);
    tick();
    check("mid_r2_busy", 32'(busy4), 32'd1);
    tick();
    check("mid_r3_lvl", 32'(dut4.lvl[2]), 32'd0);
    tick();
    check("mid_r4_lvl", 32'(dut4.lvl[2]), 32'd1);

    // Duty at lvl=128 with STEP_DIV=256: level is stable over a full PWM period
    gpio4 = 8'h00;
    apply_reset(2);
    gpiod = 8'h01;
    for (int n = 0; n < 33500; n++) begin
      tick();
      if (dutd.lvl[0] == 8'd128) break;
    end
    check("duty_reach128", 32'(dutd.lvl[0]), 32'd128);
    cnt = 0;
    for (int n = 0; n < 255; n++) begin
      tick();
      if (ledd[0]) cnt++;
    end
    check("duty_high_cycles", 32'(cnt), 32'd128);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Sits directly downstream of the Nios GPIO export (gpioa) that drives the board LEDs.
- Takes the 8-bit on/off pattern written by software and drives each LED pin with an 8-bit PWM.
- Each LED's brightness ramps linearly toward the commanded state, so LEDs fade in and out instead of switching hard.
- Runs in the 100 MHz system clock domain, the same clock as the Nios.

Parameters:
- N_LED, 8, number of LED channels (width of gpio_in / led_out).
- STEP_DIV, 3906, system-clock cycles per brightness step; 255 steps gives about a 10 ms full fade at 100 MHz. Legal range 1..65535.

Ports:
- clk  input  1  system clock (100 MHz PLL output).
- rst  input  1  synchronous reset, active-high.
- gpio_in  input  N_LED  target pattern from the Nios GPIO export; 1 = LED on, 0 = LED off. Same clock domain.
- led_out  output  N_LED  PWM-driven LED pins, registered.
- busy  output  1  high while any channel's level differs from its target extreme, registered.

Behaviour:
- One clock and a synchronous active-high reset; every register is updated only on the rising edge of clk.
- Reset (rst=1 at an edge) sets the following, and it takes priority over all other activity, including mid-fade:
  - tgt register = 0, all lvl[i] = 0, prescaler = 0, pwm_cnt = 0.
  - led_out = 0, busy = 0.
- Input stage: tgt <= gpio_in every cycle, giving 1 cycle of latency. No synchronizer is needed because the input is in the same domain.
- Prescaler:
  - Counts 0..STEP_DIV-1 and wraps to 0.
  - step_tick = 1 in the cycle where prescaler == STEP_DIV-1.
  - With STEP_DIV=1, step_tick is 1 every cycle.
- Level update: 8-bit lvl[i] per channel, changed only on step_tick.
  - tgt[i]=1 and lvl[i]<255: lvl[i] increments by 1.
  - tgt[i]=0 and lvl[i]>0: lvl[i] decrements by 1.
  - Otherwise lvl[i] holds. Saturating, never wraps.
- Per-channel state is implicit: RISING, FALLING, HOLD_ON (lvl=255, tgt=1) or HOLD_OFF (lvl=0, tgt=0).
- Target reversal mid-fade: direction flips at the next step_tick from the current lvl, with no jump or restart.
- Simultaneous tgt change and step_tick: the step uses the tgt value registered before that edge. The new tgt takes effect at the following tick.
- PWM counter: pwm_cnt counts 0..254 and wraps to 0, giving a period of 255 cycles. It is free-running and not aligned to the prescaler.
- Output: led_out[i] <= (pwm_cnt < lvl[i]).
  - lvl=0 gives a constant 0.
  - lvl=255 gives a constant 1.
  - lvl=k gives exactly k high cycles per 255-cycle period.
- busy <= OR over i of ((tgt[i]=1 and lvl[i]!=255) or (tgt[i]=0 and lvl[i]!=0)).
- Channels are independent; any mix of rising, falling and holding channels is legal in the same cycle.
- Full fade duration: 255 × STEP_DIV cycles, plus up to STEP_DIV cycles of tick phase, plus 2 cycles of register latency.

Test Plan:
- Reset: hold rst=1 for 3 cycles with gpio_in=0xFF -> led_out=0x00, busy=0 on every cycle of reset and in the first cycle after it.
- Fade in (STEP_DIV=4): after reset, gpio_in=0x01 -> busy rises 2 cycles later, lvl[0] reaches 255 within 1024 cycles, then led_out[0] is constant 1, busy=0, and led_out[7:1] stays 0 throughout.
- Duty check (STEP_DIV=4): freeze the test when lvl[0]=128 (force STEP_DIV tick off via hierarchical probe, or sample a window) -> exactly 128 high cycles of led_out[0] in any 255-cycle window.
- Reversal (STEP_DIV=4): gpio_in=0x01, switch to 0x00 when lvl[0]=100 -> lvl[0] sequence continues 100 (or 101 if a tick coincides), then 99, 98, … down to 0 with no jump; busy falls when lvl[0]=0.
- Mixed channels (STEP_DIV=1): start from all-on (0xFF settled), apply gpio_in=0x0F -> lvl[7:4] fall by 1 per cycle while lvl[3:0] stay 255; after 255+2 cycles led_out=0x0F constant and busy=0.
- Reset mid-fade: assert rst with lvl[2]=60 while rising -> the next cycle shows lvl[2]=0, led_out=0, busy=0; after release with gpio_in still 0x04, the fade restarts from 0.
